pc_next_unit: RTL



---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_adder.sv | 26 ++
 rtl/pc_next_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
// Also hosts the full-adder cell that pc_adder chains into a ripple adder.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam int unsigned PC_INC = 4;

    // Any set bit under this mask makes a redirect target misaligned.
    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    // Full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        logic s;
        logic co;
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
        return {co, s};
    endfunction

endpackage

// File: rtl/pc_adder.sv
// ADDR_W-bit ripple-carry adder built from the full-adder cell.
// The final carry-out is intentionally dropped: addresses wrap modulo 2^W.
module pc_adder
    import pc_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o
);

    always_comb begin
        logic       carry;
        logic [1:0] fa;
        sum_o = '0;
        carry = cin_i;
        for (int i = 0; i < int'(W); i++) begin
            fa       = full_add(a_i[i], b_i[i], carry);
            sum_o[i] = fa[0];
            carry    = fa[1];
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter unit: owns the PC register, the BOOT/RUN/HALTED sequencer
// and the sticky misaligned-target trap; drives the instruction fetch address.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       IMM_W     = 64,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              halt,
    input  logic              branch,
    input  logic              zero,
    input  logic              jal,
    input  logic              jalr,
    input  logic [IMM_W-1:0]  imm,
    input  logic [IMM_W-1:0]  rs1_val,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_4,
    output logic              fetch_valid,
    output logic              trap
);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              trap_q, trap_d;

    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] br_addr;
    logic [ADDR_W-1:0] jt_sum;
    logic [ADDR_W-1:0] jt_addr;
    logic [ADDR_W-1:0] target;
    logic              taken;
    logic              misaligned;

    // Only the low ADDR_W bits of the operands reach the address adders.
    logic unused_upper;
    assign unused_upper = ^{imm[IMM_W-1:ADDR_W], rs1_val[IMM_W-1:ADDR_W]};

    pc_adder #(.W(ADDR_W)) u_seq_adder (
        .a_i   (pc_q),
        .b_i   (ADDR_W'(PC_INC)),
        .cin_i (1'b0),
        .sum_o (seq_addr)
    );

    pc_adder #(.W(ADDR_W)) u_br_adder (
        .a_i   (pc_q),
        .b_i   ({imm[ADDR_W-2:0], 1'b0}),
        .cin_i (1'b0),
        .sum_o (br_addr)
    );

    pc_adder #(.W(ADDR_W)) u_jt_adder (
        .a_i   (rs1_val[ADDR_W-1:0]),
        .b_i   (imm[ADDR_W-1:0]),
        .cin_i (1'b0),
        .sum_o (jt_sum)
    );

    assign jt_addr = {jt_sum[ADDR_W-1:1], 1'b0};

    // Redirect decode, priority jalr > jal > branch.
    always_comb begin
        target = seq_addr;
        taken  = 1'b0;
        if (jalr) begin
            target = jt_addr;
            taken  = 1'b1;
        end else if (jal) begin
            target = br_addr;
            taken  = 1'b1;
        end else if (branch) begin
            target = br_addr;
            taken  = zero;
        end
    end

    assign misaligned = taken && ((target[1:0] & MISALIGN_MASK) != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        trap_d  = trap_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (misaligned) begin
                    state_d = HALTED;
                    trap_d  = 1'b1;
                end else if (stall) begin
                    // Redirect dropped; the decoder re-presents it.
                    pc_d = pc_q;
                end else if (taken) begin
                    pc_d = target;
                end else begin
                    pc_d = seq_addr;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = (state_q == RUN) && !stall;
        trap        = trap_q;
        pc          = pc_q;
        pc_plus_4   = seq_addr;
    end

endmodule
